// File: rtl/fd27_seg_display_pkg.sv
// Shared definitions for the fd27 display stage.
//   FD_W / PT_LSB / DIG_W : layout of the 27-bit decimal word
//                           ([23:0] six BCD digits, [26:24] point position)
//   SEG_LUT / SEG_BLANK / SEG_E : active-low segment codes {g,f,e,d,c,b,a}
//   has_non_bcd()        : 1 if any nibble of a 24-bit digit field exceeds 9
package fd27_seg_display_pkg;

    localparam int FD_W   = 27;
    localparam int PT_LSB = 24;
    localparam int DIG_W  = 24;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic logic has_non_bcd(input logic [DIG_W-1:0] w);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < DIG_W / 4; i++) begin
            if (w[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fd27_seg_display_bcd_to_seg7.sv
// Combinational nibble -> 7-segment decoder (active low, {g,f,e,d,c,b,a}).
//   bcd : input nibble
//   seg : segment pattern; digits 0..9 decoded, anything above 9 shows "E"
module bcd_to_seg7
    import fd27_seg_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (bcd <= 4'd9) seg = SEG_LUT[bcd];
    end

endmodule

// File: rtl/fd27_seg_display.sv
// Display stage for the binary-to-decimal converter: latches the 27-bit
// decimal word on ok_conv and scans it onto a common-anode 6-digit display.
//   clk, rst  : clock, asynchronous active-high reset
//   FDI       : [23:0] BCD digits (nibble 0 = LSD), [26:24] point position p
//   ok_conv   : 1-clk load strobe
//   blank_lz  : 1 = blank leading zeros above the point
//   AN        : digit anodes, active low, one-hot (AN[0] = rightmost)
//   SEG       : segments {g,f,e,d,c,b,a}, active low
//   DP        : decimal point, active low
//   valid     : a word has been latched since reset
//   err       : latched word contains a non-BCD nibble
module fd27_seg_display
    import fd27_seg_display_pkg::*;
#(
    parameter int N_DIG  = 6,
    parameter int F_CLK  = 50_000_000,
    parameter int F_SCAN = 1_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FD_W-1:0]  FDI,
    input  logic             ok_conv,
    input  logic             blank_lz,
    output logic [N_DIG-1:0] AN,
    output logic [6:0]       SEG,
    output logic             DP,
    output logic             valid,
    output logic             err
);

    localparam int PRESC = F_CLK / F_SCAN;
    localparam int CW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW    = $clog2(N_DIG);

    logic [CW-1:0]    presc;
    logic             tick;
    logic [IW-1:0]    idx;
    logic [FD_W-1:0]  reg_fd;

    logic [3:0]       cur_nib;
    logic [6:0]       cur_seg;
    logic [2:0]       pt;
    logic             dp_on;
    logic             blank_cur;

    logic [N_DIG-1:0] an_nx;
    logic [6:0]       seg_nx;
    logic             dp_nx;

    assign tick    = (presc == CW'(PRESC - 1));
    assign cur_nib = reg_fd[{idx, 2'b00} +: 4];
    assign pt      = reg_fd[PT_LSB +: 3];

    bcd_to_seg7 u_dec (
        .bcd (cur_nib),
        .seg (cur_seg)
    );

    // Point lights only for 1..N_DIG-1 fractional digits.
    assign dp_on = (IW'(pt) == idx) && (pt != 3'd0) && (pt <= 3'(N_DIG - 1));

    // Blank when above the point and this digit plus everything to its left
    // is zero; idx > pt also keeps digit 0 and the point digit lit.
    assign blank_cur = blank_lz && (idx > IW'(pt)) &&
                       ((reg_fd[DIG_W-1:0] >> {idx, 2'b00}) == '0);

    always_comb begin
        an_nx  = '1;
        seg_nx = SEG_BLANK;
        dp_nx  = 1'b1;
        if (valid && !blank_cur) begin
            an_nx[idx] = 1'b0;
            seg_nx     = cur_seg;
            dp_nx      = ~dp_on;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            idx    <= '0;
            reg_fd <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            AN     <= '1;
            SEG    <= SEG_BLANK;
            DP     <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + CW'(1);
            if (tick) begin
                idx <= (idx == IW'(N_DIG - 1)) ? '0 : idx + IW'(1);
            end
            if (ok_conv) begin
                reg_fd <= FDI;
                valid  <= 1'b1;
                err    <= has_non_bcd(FDI[DIG_W-1:0]);
            end
            AN  <= an_nx;
            SEG <= seg_nx;
            DP  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_fd27_seg_display.sv
module tb_fd27_seg_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S9 = 7'b0010000, SE = 7'b0000110, SB = 7'h7F;

    logic        clk;
    logic        rst;
    logic [26:0] FDI;
    logic        ok_conv;
    logic        blank_lz;
    logic [5:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        valid;
    logic        err;

    int n_tests;
    int n_fail;

    fd27_seg_display #(.F_SCAN(12_500_000)) dut (
        .clk      (clk),
        .rst      (rst),
        .FDI      (FDI),
        .ok_conv  (ok_conv),
        .blank_lz (blank_lz),
        .AN       (AN),
        .SEG      (SEG),
        .DP       (DP),
        .valid    (valid),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scan timing reference: 4 clks per digit, 6 digits; disp_idx is the digit
    // whose pattern the registered outputs currently show.
    logic [1:0] m_cnt;
    logic [2:0] m_idx;
    logic [2:0] disp_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 2'd0;
            m_idx    <= 3'd0;
            disp_idx <= 3'd0;
        end else begin
            disp_idx <= m_idx;
            if (m_cnt == 2'd3) begin
                m_cnt <= 2'd0;
                m_idx <= (m_idx == 3'd5) ? 3'd0 : m_idx + 3'd1;
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end

    task automatic load(input logic [26:0] w);
        @(negedge clk);
        FDI     = w;
        ok_conv = 1'b1;
        @(negedge clk);
        ok_conv = 1'b0;
    endtask

    task automatic test_reset();
        load({3'd0, 24'h012345});
        repeat (10) @(negedge clk);
        n_tests++;
        if (AN !== ~(6'b1 << disp_idx)) begin
            n_fail++;
            $display("FAIL reset_pre_active: AN=%h want %h", AN, ~(6'b1 << disp_idx));
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (AN !== 6'h3F || SEG !== 7'h7F || DP !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: AN=%h SEG=%h DP=%b valid=%b err=%b want 3f 7f 1 0 0",
                     AN, SEG, DP, valid, err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dark();
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            n_tests++;
            if (AN !== 6'h3F || SEG !== 7'h7F || DP !== 1'b1 || valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dark_outputs s=%0d: AN=%h SEG=%h DP=%b valid=%b want 3f 7f 1 0",
                         s, AN, SEG, DP, valid);
            end
            n_tests++;
            if (dut.idx !== m_idx) begin
                n_fail++;
                $display("FAIL dark_idx s=%0d: idx=%0d want %0d", s, dut.idx, m_idx);
            end
        end
    endtask

    task automatic test_basic();
        logic [6:0] es [6];
        logic       eb [6];
        logic [5:0] ea;
        logic [6:0] ex;
        int d;
        es = '{S5, S4, S3, S2, S1, SB};
        eb = '{0, 0, 0, 0, 0, 1};
        blank_lz = 1'b1;
        load({3'd0, 24'h012345});
        n_tests++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: valid=%b want 1", valid);
        end
        @(negedge clk);
        for (int s = 0; s < 24; s++) begin
            @(negedge clk);
            d  = int'(disp_idx);
            ea = eb[d] ? 6'h3F : ~(6'b1 << d);
            ex = eb[d] ? SB : es[d];
            n_tests++;
            if (AN !== ea || SEG !== ex || DP !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_scan digit=%0d: AN=%h SEG=%b DP=%b want %h %b 1",
                         d, AN, SEG, DP, ea, ex);
            end
        end
    endtask

    task automatic test_point();
        logic [6:0] es [6];
        logic       eb [6];
        logic [5:0] ea;
        logic [6:0] ex;
        logic       ed;
        int d;
        blank_lz = 1'b1;
        load({3'd3, 24'h000042});
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                blank_lz = 1'b0;
                @(negedge clk);
            end
            es = '{S2, S4, S0, S0, S0, S0};
            eb = (pass == 0) ? '{0, 0, 0, 0, 1, 1} : '{0, 0, 0, 0, 0, 0};
            for (int s = 0; s < 24; s++) begin
                @(negedge clk);
                d  = int'(disp_idx);
                ea = eb[d] ? 6'h3F : ~(6'b1 << d);
                ex = eb[d] ? SB : es[d];
                ed = (d == 3) ? 1'b0 : 1'b1;
                n_tests++;
                if (AN !== ea || SEG !== ex || DP !== ed) begin
                    n_fail++;
                    $display("FAIL point_scan lz=%0d digit=%0d: AN=%h SEG=%b DP=%b want %h %b %b",
                             1 - pass, d, AN, SEG, DP, ea, ex, ed);
                end
            end
        end
    endtask

    task automatic test_err();
        logic [6:0] es [6];
        logic [6:0] ex;
        int d;
        es = '{S1, S0, S0, SE, S0, S0};
        blank_lz = 1'b0;
        load({3'd0, 24'h00A001});
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b want 1", err);
        end
        @(negedge clk);
        for (int s = 0; s < 24; s++) begin
            @(negedge clk);
            d  = int'(disp_idx);
            ex = es[d];
            n_tests++;
            if (AN !== ~(6'b1 << d) || SEG !== ex || DP !== 1'b1) begin
                n_fail++;
                $display("FAIL err_scan digit=%0d: AN=%h SEG=%b DP=%b want %h %b 1",
                         d, AN, SEG, DP, ~(6'b1 << d), ex);
            end
        end
        load({3'd0, 24'h000001});
        n_tests++;
        if (err !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b valid=%b want 0 1", err, valid);
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        logic [5:0] ea;
        logic [6:0] ex;
        blank_lz = 1'b0;
        load({3'd0, 24'h999999});
        found = 1'b0;
        for (int w = 0; w < 60 && !found; w++) begin
            @(negedge clk);
            if (m_idx == 3'd2 && m_cnt == 2'd3) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL b2b_sync: tick at idx 2 not reached, found=%b want 1", found);
        end else begin
            FDI     = {3'd0, 24'h543210};
            ok_conv = 1'b1;
            @(negedge clk);
            ok_conv = 1'b0;
            // sample 0: still digit 2 of the old word; then 4 clks of digit 3, 4 of digit 4
            for (int s = 0; s < 9; s++) begin
                if (s > 0) @(negedge clk);
                if (s == 0) begin
                    ea = 6'b111011; ex = S9;
                end else if (s <= 4) begin
                    ea = 6'b110111; ex = S3;
                end else begin
                    ea = 6'b101111; ex = S4;
                end
                n_tests++;
                if (AN !== ea || SEG !== ex || DP !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_scan s=%0d: AN=%b SEG=%b DP=%b want %b %b 1",
                             s, AN, SEG, DP, ea, ex);
                end
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        FDI      = '0;
        ok_conv  = 1'b0;
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_dark();
        test_basic();
        test_point();
        test_err();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
